// File: rtl/harness_cmd_decoder.sv
// harness_cmd_decoder
//   Hardware front end for a compiled DUT. Decodes the harness command byte
//   stream and drives the DUT input bus, reset and clock-enable step strobe.
//   It also serializes a snapshot of the DUT output bus back as response bytes.
//   Commands (accepted in IDLE):
//     'j' assert DUT reset
//     'k' release DUT reset
//     'l' one-cycle step pulse
//     'm' load IN_BYTES payload bytes, first byte ends up in the MSBs
//     'h' emit OUT_WORDS*4 snapshot bytes, LSB first
//     'i' end session
//   Any other byte sets err and ends the session.
// Ports
//   clk, rst            clock (rising edge); asynchronous active-low reset
//   cmd_valid/ready/data command byte stream in
//   rsp_valid/ready/data response byte stream out
//   dut_rst, dut_step   DUT reset (active-high) and step strobe
//   dut_data_in/out     packed DUT input / output buses
//   done, err           sticky session-ended and unknown-command flags
module harness_cmd_decoder #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  input  logic [7:0]           cmd_data,
  output logic                 cmd_ready,
  output logic                 rsp_valid,
  output logic [7:0]           rsp_data,
  input  logic                 rsp_ready,
  output logic                 dut_rst,
  output logic                 dut_step,
  output logic [IN_WIDTH-1:0]  dut_data_in,
  input  logic [OUT_WIDTH-1:0] dut_data_out,
  output logic                 done,
  output logic                 err
);

  localparam int IN_BYTES   = (IN_WIDTH + 7) / 8;
  localparam int OUT_WORDS  = (OUT_WIDTH + 31) / 32;
  localparam int EMIT_BYTES = OUT_WORDS * 4;
  localparam int SNAP_W     = OUT_WORDS * 32;
  localparam int MAX_BYTES  = (IN_BYTES > EMIT_BYTES) ? IN_BYTES : EMIT_BYTES;
  localparam int CW         = $clog2(MAX_BYTES + 1);

  localparam logic [CW-1:0] LOAD_LAST = CW'(IN_BYTES - 1);
  localparam logic [CW-1:0] EMIT_LAST = CW'(EMIT_BYTES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, EMIT, HALT} state_t;

  state_t              state_q, state_n;
  logic [CW-1:0]       cnt_q, cnt_n;
  logic [SNAP_W-1:0]   snap_q, snap_n;
  logic [SNAP_W-1:0]   out_ext;
  logic                rsp_valid_n;
  logic [7:0]          rsp_data_n;
  logic                dut_rst_n, dut_step_n, done_n, err_n;
  logic [IN_WIDTH-1:0] dut_data_in_n;
  logic                accept;

  assign cmd_ready = (state_q == IDLE) || (state_q == LOAD);
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    out_ext = '0;
    out_ext[OUT_WIDTH-1:0] = dut_data_out;
  end

  always_comb begin
    state_n       = state_q;
    cnt_n         = cnt_q;
    snap_n        = snap_q;
    rsp_valid_n   = rsp_valid;
    rsp_data_n    = rsp_data;
    dut_rst_n     = dut_rst;
    dut_step_n    = 1'b0;
    dut_data_in_n = dut_data_in;
    done_n        = done;
    err_n         = err;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (cmd_data)
            8'h6A: dut_rst_n = 1'b1;
            8'h6B: dut_rst_n = 1'b0;
            8'h6C: dut_step_n = 1'b1;
            8'h6D: begin
              state_n = LOAD;
              cnt_n   = '0;
            end
            8'h68: begin
              // Byte 0 is presented together with the snapshot so that
              // rsp_valid rises on the edge that accepts 'h'.
              snap_n      = out_ext;
              rsp_data_n  = out_ext[7:0];
              rsp_valid_n = 1'b1;
              cnt_n       = '0;
              state_n     = EMIT;
            end
            8'h69: begin
              done_n  = 1'b1;
              state_n = HALT;
            end
            default: begin
              err_n   = 1'b1;
              done_n  = 1'b1;
              state_n = HALT;
            end
          endcase
        end
      end
      LOAD: begin
        if (accept) begin
          // Concatenate and truncate: also covers IN_WIDTH == 8, where the
          // whole bus is replaced by the new byte.
          dut_data_in_n = IN_WIDTH'({dut_data_in, cmd_data});
          if (cnt_q == LOAD_LAST) begin
            state_n = IDLE;
          end else begin
            cnt_n = cnt_q + CW'(1);
          end
        end
      end
      EMIT: begin
        if (rsp_valid && rsp_ready) begin
          if (cnt_q == EMIT_LAST) begin
            rsp_valid_n = 1'b0;
            state_n     = IDLE;
          end else begin
            // Snapshot shifts right so the next byte is always at [15:8].
            snap_n     = snap_q >> 8;
            rsp_data_n = snap_q[15:8];
            cnt_n      = cnt_q + CW'(1);
          end
        end
      end
      HALT: begin
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      snap_q      <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      dut_rst     <= 1'b1;
      dut_step    <= 1'b0;
      dut_data_in <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      snap_q      <= snap_n;
      rsp_valid   <= rsp_valid_n;
      rsp_data    <= rsp_data_n;
      dut_rst     <= dut_rst_n;
      dut_step    <= dut_step_n;
      dut_data_in <= dut_data_in_n;
      done        <= done_n;
      err         <= err_n;
    end
  end

endmodule

// File: tb/tb_harness_cmd_decoder.sv
// Directed bench for harness_cmd_decoder with IN_WIDTH=24, OUT_WIDTH=40.
module tb_harness_cmd_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_data = '0;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_ready = 1'b0;
  logic        dut_rst;
  logic        dut_step;
  logic [23:0] dut_data_in;
  logic [39:0] dut_data_out = '0;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  harness_cmd_decoder #(.IN_WIDTH(24), .OUT_WIDTH(40)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_data     (cmd_data),
    .cmd_ready    (cmd_ready),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_ready    (rsp_ready),
    .dut_rst      (dut_rst),
    .dut_step     (dut_step),
    .dut_data_in  (dut_data_in),
    .dut_data_out (dut_data_out),
    .done         (done),
    .err          (err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Present one byte from a negedge, wait (bounded) for cmd_ready, and
  // return 1 ns after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = b;
    while (!cmd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) check("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Collect nbytes response bytes and compare them with exp (LSB first).
  // dut_data_out is disturbed mid-stream to show the snapshot is isolated.
  task automatic collect(input logic [63:0] exp, input int nbytes, input bit rnd);
    int got = 0;
    int cyc = 0;
    bit stall = 1'b0;
    logic [7:0] prev = '0;
    while (got < nbytes && cyc < 200) begin
      @(negedge clk);
      rsp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (got == 2) dut_data_out = 40'h01_02030405;
      check("rsp_valid_high", 64'(rsp_valid), 64'd1);
      if (stall) check("rsp_hold", 64'(rsp_data), 64'(prev));
      if (rsp_valid && rsp_ready) begin
        check($sformatf("rsp_byte%0d", got), 64'(rsp_data), 64'(exp[got*8 +: 8]));
        got++;
        stall = 1'b0;
      end else begin
        stall = rsp_valid;
        prev  = rsp_data;
      end
      cyc++;
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    if (got < nbytes) check("emit_timeout", 64'(got), 64'(nbytes));
  endtask

  initial begin
    // 1. Reset state and DUT reset control
    #12;
    check("rst_dut_rst",   64'(dut_rst), 64'd1);
    check("rst_step",      64'(dut_step), 64'd0);
    check("rst_data_in",   64'(dut_data_in), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_done",      64'(done), 64'd0);
    check("rst_err",       64'(err), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("idle_ready", 64'(cmd_ready), 64'd1);
    check("idle_dut_rst", 64'(dut_rst), 64'd1);
    send_byte(8'h6B);
    check("k_dut_rst", 64'(dut_rst), 64'd0);
    send_byte(8'h6A);
    check("j_dut_rst", 64'(dut_rst), 64'd1);

    // 2. Payload load, then a step to confirm return to IDLE
    send_byte(8'h6D);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    check("load1", 64'(dut_data_in), 64'h123456);
    send_byte(8'h6C);
    check("load1_idle_step", 64'(dut_step), 64'd1);
    send_byte(8'h6D);
    send_byte(8'hAB);
    send_byte(8'hCD);
    send_byte(8'hEF);
    check("load2", 64'(dut_data_in), 64'hABCDEF);

    // 3. Emit with random back-pressure
    dut_data_out = 40'h99_AABBCCDD;
    send_byte(8'h68);
    check("emit_ready_low", 64'(cmd_ready), 64'd0);
    collect(64'h00000099_AABBCCDD, 8, 1'b1);
    check("emit_end_valid", 64'(rsp_valid), 64'd0);
    check("emit_end_ready", 64'(cmd_ready), 64'd1);

    // 4. Back-to-back steps
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = 8'h6C;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("step%0d", i), 64'(dut_step), 64'd1);
    end
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("step_end", 64'(dut_step), 64'd0);

    // 5. Unknown command halts; HALT ignores input
    send_byte(8'h6B);
    send_byte(8'h41);
    check("bad_err",   64'(err), 64'd1);
    check("bad_done",  64'(done), 64'd1);
    check("bad_ready", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = 8'h6A;
    @(posedge clk); #1;
    cmd_data  = 8'h6C;
    @(posedge clk); #1;
    check("halt_dut_rst", 64'(dut_rst), 64'd0);
    check("halt_step",    64'(dut_step), 64'd0);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst2_done", 64'(done), 64'd0);
    check("rst2_err",  64'(err), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    send_byte(8'h69);
    check("i_done",  64'(done), 64'd1);
    check("i_err",   64'(err), 64'd0);
    check("i_ready", 64'(cmd_ready), 64'd0);

    // 6. Reset in the middle of an emission, then a complete emission
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    dut_data_out = 40'h99_AABBCCDD;
    send_byte(8'h68);
    collect(64'h00000099_AABBCCDD, 3, 1'b0);
    check("mid_valid", 64'(rsp_valid), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_valid", 64'(rsp_valid), 64'd0);
    check("async_data",  64'(rsp_data), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    dut_data_out = 40'h12_CAFEBABE;
    send_byte(8'h68);
    collect(64'h00000012_CAFEBABE, 8, 1'b0);
    check("emit2_end_valid", 64'(rsp_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
